// File: rtl/gru_pkg.sv
// Shared constants and encodings for the GRU gate activation path.
// Q4.4 lane format, activation selects and controller states.
package gru_pkg;

    localparam int GRU_DATA_WIDTH = 8;
    localparam int GRU_FRAC       = 4;
    localparam int ONE            = 16;
    localparam int HALF           = 8;

    localparam int ACT_SIGMOID = 0;
    localparam int ACT_TANH    = 1;

    typedef enum logic [1:0] {
        S_WX  = 2'd0,
        S_UH  = 2'd1,
        S_ACT = 2'd2,
        S_OUT = 2'd3
    } gate_state_t;

endpackage

// File: rtl/gru_lane_act.sv
// Single-lane three-way add, saturate and activate.
// Purely combinational; shared by the gate and candidate stages.
module gru_lane_act
    import gru_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC       = 4,
    parameter int ACT        = 0
) (
    input  logic [DATA_WIDTH-1:0] i_wx,
    input  logic [DATA_WIDTH-1:0] i_uh,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_y
);

    localparam int SW = DATA_WIDTH + 2;
    localparam int W1 = DATA_WIDTH + 1;

    localparam logic signed [SW-1:0] SUM_MAX =
        {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN =
        {3'b111, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] ONE_D =
        DATA_WIDTH'(1 << FRAC);
    localparam logic signed [DATA_WIDTH-1:0] NEG_ONE_D = -ONE_D;
    localparam logic signed [W1-1:0] ONE_W  = W1'(1 << FRAC);
    localparam logic signed [W1-1:0] HALF_W = W1'(1 << (FRAC - 1));

    logic signed [SW-1:0]         w_sum;
    logic signed [DATA_WIDTH-1:0] w_sat;
    logic signed [W1-1:0]         w_sig;
    logic [DATA_WIDTH-1:0]        w_y_sig;
    logic [DATA_WIDTH-1:0]        w_y_tanh;

    // add, saturate to lane range, then both activation curves
    always_comb begin
        w_sum = SW'($signed(i_wx)) + SW'($signed(i_uh))
              + SW'($signed(i_b));

        if (w_sum > SUM_MAX)
            w_sat = SAT_MAX;
        else if (w_sum < SUM_MIN)
            w_sat = SAT_MIN;
        else
            w_sat = w_sum[DATA_WIDTH-1:0];

        // hard-sigmoid: slope 1/4 around 0.5, clamped to [0, 1]
        w_sig = W1'(w_sat >>> 2) + HALF_W;
        if (w_sig[W1-1])
            w_y_sig = '0;
        else if (w_sig > ONE_W)
            w_y_sig = ONE_D;
        else
            w_y_sig = w_sig[DATA_WIDTH-1:0];

        // hard-tanh: identity clamped to [-1, 1]
        if (w_sat > ONE_D)
            w_y_tanh = ONE_D;
        else if (w_sat < NEG_ONE_D)
            w_y_tanh = NEG_ONE_D;
        else
            w_y_tanh = w_sat;

        o_y = (ACT == ACT_TANH) ? w_y_tanh : w_y_sig;
    end

endmodule

// File: rtl/gru_gate_act.sv
// GRU gate collector: gathers W.x and U.h vectors, then
// activates one lane per cycle through a shared lane unit.
module gru_gate_act
    import gru_pkg::*;
#(
    parameter int H          = 6,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC       = 4,
    parameter int ACT        = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sel,
    input  logic [H*DATA_WIDTH-1:0] in_data,
    input  logic [H*DATA_WIDTH-1:0] bias_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [H*DATA_WIDTH-1:0] out_data,
    output logic                    seq_err
);

    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    gate_state_t             r_state;
    logic [H*DATA_WIDTH-1:0] r_wx;
    logic [H*DATA_WIDTH-1:0] r_uh;
    logic [H*DATA_WIDTH-1:0] r_b;
    logic [H*DATA_WIDTH-1:0] r_out;
    logic [CW-1:0]           r_cnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_seq_err;

    logic [DATA_WIDTH-1:0]   w_wx;
    logic [DATA_WIDTH-1:0]   w_uh;
    logic [DATA_WIDTH-1:0]   w_b;
    logic [DATA_WIDTH-1:0]   w_y;
    logic                    w_hs;

    assign w_hs = in_valid && r_in_ready;
    assign w_wx = r_wx[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_uh = r_uh[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_b  = r_b[r_cnt*DATA_WIDTH +: DATA_WIDTH];

    gru_lane_act #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC       (FRAC),
        .ACT        (ACT)
    ) u_lane (
        .i_wx (w_wx),
        .i_uh (w_uh),
        .i_b  (w_b),
        .o_y  (w_y)
    );

    // sequence beats, sweep lanes, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_WX;
            r_wx        <= '0;
            r_uh        <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            unique case (r_state)
                S_WX: begin
                    if (w_hs) begin
                        if (!in_sel) begin
                            r_wx    <= in_data;
                            r_state <= S_UH;
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                end
                S_UH: begin
                    if (w_hs) begin
                        if (in_sel) begin
                            r_uh       <= in_data;
                            r_b        <= bias_in;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_ACT;
                        end else begin
                            r_wx      <= in_data;
                            r_seq_err <= 1'b1;
                        end
                    end
                end
                S_ACT: begin
                    r_out[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_y;
                    if (r_cnt == LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_WX;
                    end
                end
                default: r_state <= S_WX;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_gru_gate_act.sv
// Scoreboard bench for gru_gate_act, sigmoid and tanh
// instances driven in lockstep from the same stimulus.
module tb_gru_gate_act;

    localparam int H  = 6;
    localparam int DW = 8;
    localparam int VW = H * DW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_sel;
    logic [VW-1:0] in_data;
    logic [VW-1:0] bias_in;
    logic          out_ready;

    logic          ir_s, ov_s, se_s;
    logic          ir_t, ov_t, se_t;
    logic [VW-1:0] od_s, od_t;

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] q_s[$];
    logic [VW-1:0] q_t[$];

    gru_gate_act #(.H(H), .DATA_WIDTH(DW), .FRAC(4), .ACT(0)) u_sig (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ir_s),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .bias_in   (bias_in),
        .out_valid (ov_s),
        .out_ready (out_ready),
        .out_data  (od_s),
        .seq_err   (se_s)
    );

    gru_gate_act #(.H(H), .DATA_WIDTH(DW), .FRAC(4), .ACT(1)) u_tanh (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ir_t),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .bias_in   (bias_in),
        .out_valid (ov_t),
        .out_ready (out_ready),
        .out_data  (od_t),
        .seq_err   (se_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_lane(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c,
                                              input int act);
        int s;
        int y;
        s = int'($signed(a)) + int'($signed(b)) + int'($signed(c));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (act == 0) begin
            y = (s >>> 2) + 8;
            if (y < 0) y = 0;
            if (y > 16) y = 16;
        end else begin
            y = s;
            if (y < -16) y = -16;
            if (y > 16) y = 16;
        end
        return y[7:0];
    endfunction

    function automatic logic [VW-1:0] model_vec(input logic [VW-1:0] wx,
                                                input logic [VW-1:0] uh,
                                                input logic [VW-1:0] b,
                                                input int act);
        logic [VW-1:0] r;
        r = '0;
        for (int m = 0; m < H; m++)
            r[m*DW +: DW] = model_lane(wx[m*DW +: DW], uh[m*DW +: DW],
                                       b[m*DW +: DW], act);
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        r[31:0]  = $urandom();
        r[47:32] = 16'($urandom());
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sel, input logic [VW-1:0] d,
                        input logic [VW-1:0] b);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        bias_in  = b;
        tick();
        in_valid = 1'b0;
        in_data  = {16'h0, $urandom()};
        bias_in  = {16'h0, $urandom()};
    endtask

    task automatic push_exp(input logic [VW-1:0] wx,
                            input logic [VW-1:0] uh,
                            input logic [VW-1:0] b);
        q_s.push_back(model_vec(wx, uh, b, 0));
        q_t.push_back(model_vec(wx, uh, b, 1));
    endtask

    task automatic gate(input logic [VW-1:0] wx, input logic [VW-1:0] uh,
                        input logic [VW-1:0] b);
        push_exp(wx, uh, b);
        beat(1'b0, wx, '0);
        beat(1'b1, uh, b);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!(ov_s && ov_t) && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++;
        if (ir_s !== 1'b1 || ir_t !== 1'b1 || ov_s !== 1'b0 ||
            ov_t !== 1'b0 || se_s !== 1'b0 || se_t !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got ir=%b%b ov=%b%b se=%b%b exp ir=11 ov=00 se=00",
                     ir_s, ir_t, ov_s, ov_t, se_s, se_t);
        end
        total++;
        if (od_s !== '0 || od_t !== '0) begin
            bad++;
            $display("FAIL reset_data got %h/%h exp 0", od_s, od_t);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int n;
        logic [VW-1:0] es, et;
        gate({6{8'h10}}, {6{8'h08}}, '0);
        wait_valid(n);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL nominal_latency got=%0d exp=6", n);
        end
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_s !== {6{8'h0E}} || od_s !== es) begin
            bad++;
            $display("FAIL nominal_sig got=%h exp=%h", od_s, es);
        end
        total++;
        if (od_t !== {6{8'h10}} || od_t !== et) begin
            bad++;
            $display("FAIL nominal_tanh got=%h exp=%h", od_t, et);
        end
        repeat (3) tick();
        total++;
        if (ov_s !== 1'b1 || ov_t !== 1'b1 || od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL nominal_hold got ov=%b%b exp 11", ov_s, ov_t);
        end
        accept();
        total++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1 || ov_t !== 1'b0 || ir_t !== 1'b1) begin
            bad++;
            $display("FAIL nominal_release got ov=%b ir=%b exp ov=0 ir=1", ov_s, ir_s);
        end
        gate({6{8'hF8}}, '0, '0);
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_t !== {6{8'hF8}} || od_t !== et) begin
            bad++;
            $display("FAIL neg_tanh got=%h exp=%h", od_t, et);
        end
        total++;
        if (od_s !== {6{8'h06}} || od_s !== es) begin
            bad++;
            $display("FAIL neg_sig got=%h exp=%h", od_s, es);
        end
        accept();
    endtask

    task automatic test_saturation();
        int n;
        logic [VW-1:0] es, et, mix;
        gate({6{8'h7F}}, {6{8'h7F}}, {6{8'h7F}});
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_s !== {6{8'h10}} || od_t !== {6{8'h10}} ||
            od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL sat_pos got=%h/%h exp=%h/%h", od_s, od_t, es, et);
        end
        accept();
        gate({6{8'h80}}, {6{8'h80}}, {6{8'h80}});
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_s !== {6{8'h00}} || od_t !== {6{8'hF0}} ||
            od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL sat_neg got=%h/%h exp=%h/%h", od_s, od_t, es, et);
        end
        accept();
        mix = 48'h80_05_FD_12_E0_7F;
        gate(mix, mix, mix);
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_s[7:0] !== 8'h10 || od_s[47:40] !== 8'h00 ||
            od_t[7:0] !== 8'h10 || od_t[47:40] !== 8'hF0) begin
            bad++;
            $display("FAIL sat_mix_lanes got=%h/%h", od_s, od_t);
        end
        total++;
        if (od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL sat_mix got=%h/%h exp=%h/%h", od_s, od_t, es, et);
        end
        accept();
    endtask

    task automatic test_ordering();
        int n;
        logic [VW-1:0] wa, wb, uh, b, es, et;
        beat(1'b1, {6{8'h33}}, '0);
        total++;
        if (se_s !== 1'b1 || se_t !== 1'b1 || ir_s !== 1'b1) begin
            bad++;
            $display("FAIL order_uh_first got se=%b%b ir=%b exp se=11 ir=1",
                     se_s, se_t, ir_s);
        end
        tick();
        total++;
        if (se_s !== 1'b0 || se_t !== 1'b0) begin
            bad++;
            $display("FAIL order_pulse got se=%b%b exp 00", se_s, se_t);
        end
        wa = rnd_vec();
        wb = rnd_vec();
        uh = rnd_vec();
        b  = rnd_vec();
        beat(1'b0, wa, '0);
        total++;
        if (se_s !== 1'b0 || se_t !== 1'b0) begin
            bad++;
            $display("FAIL order_first_wx got se=%b%b exp 00", se_s, se_t);
        end
        beat(1'b0, wb, '0);
        total++;
        if (se_s !== 1'b1 || se_t !== 1'b1) begin
            bad++;
            $display("FAIL order_second_wx got se=%b%b exp 11", se_s, se_t);
        end
        push_exp(wb, uh, b);
        beat(1'b1, uh, b);
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (n != 6 || od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL order_replace got=%h/%h n=%0d exp=%h/%h n=6",
                     od_s, od_t, n, es, et);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int n;
        logic [VW-1:0] es, et, snap_s, snap_t, w2, u2, b2;
        gate(rnd_vec(), rnd_vec(), rnd_vec());
        wait_valid(n);
        snap_s = od_s;
        snap_t = od_t;
        w2 = rnd_vec();
        u2 = rnd_vec();
        b2 = rnd_vec();
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = w2;
        bias_in  = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ov_s !== 1'b1 || ov_t !== 1'b1 || ir_s !== 1'b0 ||
                ir_t !== 1'b0 || od_s !== snap_s || od_t !== snap_t) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b exp ov=1 ir=0",
                         i, ov_s, ir_s);
            end
        end
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL bp_data got=%h/%h exp=%h/%h", od_s, od_t, es, et);
        end
        accept();
        total++;
        if (ir_s !== 1'b1 || ov_s !== 1'b0 || ir_t !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", ir_s, ov_s);
        end
        tick();
        push_exp(w2, u2, b2);
        in_sel  = 1'b1;
        in_data = u2;
        bias_in = b2;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (n != 6 || od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL bp_next got=%h/%h n=%0d exp=%h/%h", od_s, od_t, n, es, et);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [VW-1:0] es, et, prev_s, prev_t, wx;
        for (int k = 0; k < 4; k++) begin
            prev_s = od_s;
            prev_t = od_t;
            wx = rnd_vec();
            push_exp(wx, 48'h0, 48'h0);
            beat(1'b0, wx, '0);
            total++;
            if (od_s !== prev_s || od_t !== prev_t) begin
                bad++;
                $display("FAIL b2b_stable k=%0d got=%h exp=%h", k, od_s, prev_s);
            end
            q_s.pop_back();
            q_t.pop_back();
            begin
                logic [VW-1:0] uh, b;
                uh = rnd_vec();
                b  = rnd_vec();
                push_exp(wx, uh, b);
                beat(1'b1, uh, b);
            end
            wait_valid(n);
            es = q_s.size() > 0 ? q_s.pop_front() : 'x;
            et = q_t.size() > 0 ? q_t.pop_front() : 'x;
            total++;
            if (n != 6 || od_s !== es || od_t !== et) begin
                bad++;
                $display("FAIL b2b k=%0d got=%h/%h n=%0d exp=%h/%h",
                         k, od_s, od_t, n, es, et);
            end
            accept();
            total++;
            if (ir_s !== 1'b1 || ir_t !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready k=%0d got ir=%b%b exp 11", k, ir_s, ir_t);
            end
        end
    endtask

    task automatic test_reset_mid_act();
        int n;
        logic [VW-1:0] es, et;
        gate({6{8'h10}}, {6{8'h08}}, '0);
        q_s.pop_back();
        q_t.pop_back();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ov_s !== 1'b0 || ov_t !== 1'b0 || od_s !== '0 || od_t !== '0 ||
            ir_s !== 1'b1 || ir_t !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid got ov=%b ir=%b data=%h exp ov=0 ir=1 data=0",
                     ov_s, ir_s, od_s);
        end
        gate(rnd_vec(), rnd_vec(), rnd_vec());
        wait_valid(n);
        es = q_s.size() > 0 ? q_s.pop_front() : 'x;
        et = q_t.size() > 0 ? q_t.pop_front() : 'x;
        total++;
        if (n != 6 || od_s !== es || od_t !== et) begin
            bad++;
            $display("FAIL rst_after got=%h/%h n=%0d exp=%h/%h", od_s, od_t, n, es, et);
        end
        accept();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 1'b0;
        in_data   = '0;
        bias_in   = '0;
        out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_saturation();
        test_ordering();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_act();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
